// File: rtl/mesh_router_vc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_router_vc_pkg
//  Purpose  : Shared definitions for the virtual-channel mesh router:
//             port index map, VC width helper, header field offsets and the
//             round-robin pick helper used by every output arbiter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mesh_router_vc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = 3;

  typedef logic [PORT_W-1:0] port_idx_t;

  // Port index map
  localparam port_idx_t PORT_PE    = 3'd0;
  localparam port_idx_t PORT_UP    = 3'd1;
  localparam port_idx_t PORT_DOWN  = 3'd2;
  localparam port_idx_t PORT_LEFT  = 3'd3;
  localparam port_idx_t PORT_RIGHT = 3'd4;

  typedef struct packed {
    logic      found;
    port_idx_t idx;
  } grant_t;

  // Width of the phase counter; a single-VC router still needs one bit.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Header layout: destX occupies the top COORD_W bits, destY the next ones.
  function automatic int dest_x_msb(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int dest_y_msb(input int data_w, input int coord_w);
    return data_w - 1 - coord_w;
  endfunction

  function automatic port_idx_t rr_next(input port_idx_t idx);
    return (idx == port_idx_t'(NUM_PORTS - 1)) ? '0 : port_idx_t'(idx + 3'd1);
  endfunction

  // Round-robin pick starting at ptr, ascending with wrap. The loop walks the
  // search order backwards so the last hit written is the first in order.
  function automatic grant_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                     input port_idx_t ptr);
    grant_t    g;
    logic [3:0] sum;
    port_idx_t idx;
    g = '{found: 1'b0, idx: '0};
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
      if (req[idx]) begin
        g.found = 1'b1;
        g.idx   = idx;
      end
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_router_vc_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_vc_fifo
//  Purpose  : Per-(port, VC) input FIFO with synchronous active-high reset.
//             Push when full and pop when empty are ignored; a simultaneous
//             push and pop both take effect and leave the count unchanged.
//  Ports    : clk, reset        - clock / sync reset
//             push, push_data   - write strobe and data
//             pop               - remove head entry
//             head              - current head data
//             empty, full       - occupancy flags (registered count based)
//  Revision : 1.0 - initial release
// ============================================================================
module mesh_vc_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only observed while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesh_router_vc.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_router_vc
//  Purpose  : 5-port 2D-mesh router with time-multiplexed virtual channels.
//             A free-running phase selects the active VC each cycle; input
//             FIFOs per (port, VC) feed XY routing and per-(output, VC)
//             round-robin arbiters that load one-entry output buffers.
//  Ports    : clk, reset            - clock / sync active-high reset
//             phase                 - current VC phase
//             in_send/in_ready      - per-port input handshake
//             in_data               - flattened input data (port i at i*DATA_W)
//             out_send/out_ready    - per-port output handshake
//             out_data              - flattened output data
//             in_drop               - sticky per-port overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module mesh_router_vc
  import mesh_router_vc_pkg::*;
#(
  parameter  int DATA_W     = 64,
  parameter  int NUM_VC     = 2,
  parameter  int FIFO_DEPTH = 2,
  parameter  int COORD_W    = 4,
  parameter  int MY_X       = 0,
  parameter  int MY_Y       = 0,
  localparam int VC_W       = vc_width(NUM_VC)
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [VC_W-1:0]             phase,
  input  logic [NUM_PORTS-1:0]        in_send,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        out_send,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]        in_drop
);

  localparam int                 DX_MSB = dest_x_msb(DATA_W);
  localparam int                 DY_MSB = dest_y_msb(DATA_W, COORD_W);
  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  // XY routing: resolve X completely before looking at Y.
  function automatic port_idx_t route(input logic [DATA_W-1:0] pkt);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    port_idx_t          res;
    dx = pkt[DX_MSB -: COORD_W];
    dy = pkt[DY_MSB -: COORD_W];
    if (dx > MY_X_C)      res = PORT_RIGHT;
    else if (dx < MY_X_C) res = PORT_LEFT;
    else if (dy > MY_Y_C) res = PORT_DOWN;
    else if (dy < MY_Y_C) res = PORT_UP;
    else                  res = PORT_PE;
    return res;
  endfunction

  // FIFO interface, one element per (port, VC)
  logic              fifo_push  [NUM_PORTS][NUM_VC];
  logic              fifo_pop   [NUM_PORTS][NUM_VC];
  logic              fifo_full  [NUM_PORTS][NUM_VC];
  logic              fifo_empty [NUM_PORTS][NUM_VC];
  logic [DATA_W-1:0] fifo_head  [NUM_PORTS][NUM_VC];

  // Output buffers and arbiter state, one per (output, VC)
  logic              ob_valid [NUM_PORTS][NUM_VC];
  logic [DATA_W-1:0] ob_data  [NUM_PORTS][NUM_VC];
  port_idx_t         rr_ptr   [NUM_PORTS][NUM_VC];

  // Active-phase views
  logic [NUM_PORTS-1:0] head_valid;
  logic [DATA_W-1:0]    head_data [NUM_PORTS];
  port_idx_t            head_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] req       [NUM_PORTS];
  grant_t               grant     [NUM_PORTS];
  logic [NUM_PORTS-1:0] load;
  logic [NUM_PORTS-1:0] popped;

  always_ff @(posedge clk) begin
    if (reset || NUM_VC == 1) phase <= '0;
    else                      phase <= phase + VC_W'(1);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      mesh_vc_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push[p][v]),
        .push_data (in_data[p*DATA_W +: DATA_W]),
        .pop       (fifo_pop[p][v]),
        .head      (fifo_head[p][v]),
        .empty     (fifo_empty[p][v]),
        .full      (fifo_full[p][v])
      );
    end
  end

  // Fullness comes from the registered count, so a same-cycle pop does not
  // open space for a push.
  always_comb begin
    head_valid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_ready[p]   = !reset && !fifo_full[p][phase];
      head_valid[p] = !fifo_empty[p][phase];
      head_data[p]  = fifo_head[p][phase];
      head_dest[p]  = route(fifo_head[p][phase]);
    end
  end

  // Only heads of the active VC compete, and each head routes to exactly one
  // output, so no head can be granted twice in a cycle.
  always_comb begin
    out_send = '0;
    out_data = '0;
    load     = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_send[o]                 = !reset && ob_valid[o][phase] && out_ready[o];
      out_data[o*DATA_W +: DATA_W] = ob_data[o][phase];
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = head_valid[i] && (head_dest[i] == port_idx_t'(o));
      end
      grant[o] = rr_pick(req[o], rr_ptr[o][phase]);
      // A buffer being drained this cycle may be refilled at the same edge.
      load[o]  = !reset && grant[o].found && (!ob_valid[o][phase] || out_send[o]);
    end
  end

  always_comb begin
    popped = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (load[o]) popped[grant[o].idx] = 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        fifo_push[p][v] = (phase == VC_W'(v)) && in_send[p] && in_ready[p];
        fifo_pop[p][v]  = (phase == VC_W'(v)) && popped[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          ob_valid[o][v] <= 1'b0;
          rr_ptr[o][v]   <= '0;
        end
      end
      in_drop <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (load[o]) begin
          ob_valid[o][phase] <= 1'b1;
          ob_data[o][phase]  <= head_data[grant[o].idx];
          rr_ptr[o][phase]   <= rr_next(grant[o].idx);
        end else if (out_send[o]) begin
          ob_valid[o][phase] <= 1'b0;
        end
      end
      in_drop <= in_drop | (in_send & ~in_ready);
    end
  end

endmodule
`default_nettype wire
